sub_bytes_iter: RTL and testbench
=================================

Name: sub_bytes_iter

Overview:
Iterative AES SubBytes stage. It sits directly upstream of the ShiftRows stage in the round datapath and drives that stage's 128-bit input.
- Accepts one 128-bit state through a valid/ready handshake.
- Substitutes BYTES_PER_CYCLE bytes per clock using shared S-box lanes.
- Presents the substituted state with valid/ready until it is consumed.
- Supports forward (encrypt) and inverse (decrypt) S-box, selected per block.

Parameters:
BYTES_PER_CYCLE, 4, S-box lanes instantiated; legal values 1, 2, 4, 8, 16; K = 16/BYTES_PER_CYCLE iterations per block.

Ports:
iClk  input  1  clock; all logic on rising edge
iRst  input  1  reset, synchronous, active-high
iValid  input  1  upstream state valid
oReady  output  1  block can accept a state
iText  input  128  state in; byte k = bits [127-8k -:8], column-major (byte 0 = row0/col0, byte 1 = row1/col0, ...)
iInv  input  1  1 = inverse S-box; sampled only on accept
oValid  output  1  oSubText valid
iReady  input  1  downstream accepts oSubText
oSubText  output  128  substituted state, same byte ordering as iText

Behaviour:
- Reset (iRst high at an edge):
  - state=IDLE, oReady=1, oValid=0, oSubText=0, iteration counter=0, latched inv=0.
  - Reset takes priority over every other event.
- States: IDLE, RUN, DONE. Encoding is binary; oReady and oValid are registered.
- IDLE:
  - oReady=1, oValid=0.
  - On an edge with iValid=1: capture iText into the work register, latch iInv, cnt=0, go to RUN, oReady falls.
- RUN:
  - oReady=0, oValid=0.
  - Each edge replaces chunk cnt (bytes cnt*N .. cnt*N+N-1, N=BYTES_PER_CYCLE) with S(byte) or InvS(byte) per latched inv. Untouched bytes hold.
  - cnt increments; on the edge that processes chunk K-1, go to DONE and set oValid=1.
- Latency: oValid is high exactly K cycles after the accept edge (K=4 at default).
- DONE:
  - oValid=1, oSubText held stable.
  - oReady=0; iValid is ignored and upstream must hold.
  - On an edge with iReady=1: oValid=0, go to IDLE.
  - Minimum initiation interval is K+2 cycles.
- oSubText is wired directly from the work register. Its content is only defined when oValid=1; intermediate values may be visible during RUN.
- iValid in RUN or DONE has no effect. iInv changes after accept have no effect.
- iReady in IDLE or RUN has no effect.
- Reset mid-RUN or mid-DONE: the partial or pending result is discarded. The block is back in IDLE with oReady=1 after the reset edge, and no oValid pulse is produced for the aborted block.
- K=1 (N=16): RUN lasts one cycle, latency 1.
- The counter width is max(1, log2(K)). It never wraps past K-1 because it is reset to 0 on accept.

Decomposition:
- Shared include aes_defs.vh holds:
  - AES_BLOCK_BITS=128 and AES_BYTE_BITS=8.
  - Byte-index slice macros for the column-major ordering, shared with ShiftRows/MixColumns.
  - SubBytes FSM state encodings.
- Sub-module aes_sbox: combinational, 8-bit in, iInv, 8-bit out; forward and inverse FIPS-197 tables. One instance per lane, generated BYTES_PER_CYCLE times.
- Lane-select mux and write-back live in sub_bytes_iter.

Test Plan:
1. Assert iRst for 2 cycles -> oValid=0, oReady=1, oSubText=0; iValid pulses during reset are not accepted.
2. iText=193de3bea0f4e22b9ac68d2ae9f84808, iInv=0, iReady=1 -> oValid high exactly 4 cycles after the accept edge with oSubText=d42711aee0bf98f1b8b45de51e415230; oReady=1 again one cycle after.
3. iText=d42711aee0bf98f1b8b45de51e415230, iInv=1 -> oSubText=193de3bea0f4e22b9ac68d2ae9f84808. Then all-0x00 with iInv=0 -> all-0x63, and all-0xFF -> all-0x16.
4. Backpressure: iReady=0 for 6 cycles after oValid, with iValid held high and iText changed -> oValid and oSubText stable, oReady=0, no new accept. The new block is accepted only after iReady=1 and the return to IDLE.
5. iRst asserted 2 cycles into RUN -> IDLE/oReady=1 next cycle, no oValid for that block. A following block 00112233445566778899aabbccddeeff gives 638293c31bfc33f5c4eeacea4bc12816.
6. Rebuild with BYTES_PER_CYCLE=1 and 16, rerun scenario 2 -> identical oSubText with latency 16 and 1 cycles respectively.

Source files
------------

// File: rtl/sub_bytes_iter_pkg.sv
// Shared AES definitions for the SubBytes stage: block geometry, FSM states
// and GF(2^8) helpers used to build the forward and inverse S-boxes.
package sub_bytes_iter_pkg;

  localparam int unsigned AES_BLOCK_BITS  = 128;
  localparam int unsigned AES_BYTE_BITS   = 8;
  localparam int unsigned AES_BLOCK_BYTES = AES_BLOCK_BITS / AES_BYTE_BITS;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_RUN  = 2'd1,
    SB_DONE = 2'd2
  } sb_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    return aff_fwd(gf_inv(x));
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv(aff_inv(x));
  endfunction

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Valid/ready handshake bundle between the round datapath, SubBytes and ShiftRows.
interface sub_bytes_iter_if;

  logic                                        iValid;
  logic                                        oReady;
  logic [sub_bytes_iter_pkg::AES_BLOCK_BITS-1:0] iText;
  logic                                        iInv;
  logic                                        oValid;
  logic                                        iReady;
  logic [sub_bytes_iter_pkg::AES_BLOCK_BITS-1:0] oSubText;

  modport slave (
    input  iValid, iText, iInv, iReady,
    output oReady, oValid, oSubText
  );

  modport master (
    output iValid, iText, iInv, iReady,
    input  oReady, oValid, oSubText
  );

endinterface

// File: rtl/sub_bytes_iter_sbox.sv
// One combinational S-box lane: forward or inverse FIPS-197 substitution.
module aes_sbox
  import sub_bytes_iter_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic       i_inv,
  output logic [7:0] o_byte_c
);

  assign o_byte_c = i_inv ? sbox_inv(i_byte) : sbox_fwd(i_byte);

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes BYTES_PER_CYCLE bytes per clock through
// shared S-box lanes and holds the result until downstream consumes it.
module sub_bytes_iter
  import sub_bytes_iter_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  sub_bytes_iter_if.slave   bus
);

  localparam int unsigned N     = BYTES_PER_CYCLE;
  localparam int unsigned K     = AES_BLOCK_BYTES / N;
  localparam int unsigned CW    = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned LOG_N = $clog2(N);

  if (!(N == 1 || N == 2 || N == 4 || N == 8 || N == 16)) begin : g_bad_param
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  sb_state_e                 r_state, w_state_nxt;
  logic [CW-1:0]             r_cnt, w_cnt_nxt;
  logic                      r_inv, w_inv_nxt;
  logic [AES_BLOCK_BITS-1:0] r_work, w_work_nxt;
  logic                      r_ready, r_valid;

  logic [7:0]                w_bytes     [AES_BLOCK_BYTES];
  logic [7:0]                w_sub_bytes [AES_BLOCK_BYTES];
  logic [7:0]                w_lane_in   [N];
  logic [7:0]                w_lane_out  [N];
  logic [3:0]                w_base;
  logic [AES_BLOCK_BITS-1:0] w_work_sub;
  logic                      w_last;

  // Column-major byte view of the work register (byte 0 in the MSBs).
  for (genvar g = 0; g < AES_BLOCK_BYTES; g++) begin : g_bytes
    assign w_bytes[g] = r_work[AES_BLOCK_BITS-1-8*g -: 8];
    assign w_work_sub[AES_BLOCK_BITS-1-8*g -: 8] = w_sub_bytes[g];
  end

  assign w_base = 4'(r_cnt) << LOG_N;
  assign w_last = (r_cnt == CW'(K - 1));

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign w_lane_in[g] = w_bytes[w_base + 4'(g)];
    aes_sbox u_sbox (
      .i_byte   (w_lane_in[g]),
      .i_inv    (r_inv),
      .o_byte_c (w_lane_out[g])
    );
  end

  // Write the current chunk back; all other bytes hold.
  always_comb begin
    for (int k = 0; k < AES_BLOCK_BYTES; k++) w_sub_bytes[k] = w_bytes[k];
    for (int j = 0; j < N; j++) w_sub_bytes[w_base + 4'(j)] = w_lane_out[j];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_inv_nxt   = r_inv;
    w_work_nxt  = r_work;
    unique case (r_state)
      SB_IDLE: begin
        if (bus.iValid) begin
          w_work_nxt  = bus.iText;
          w_inv_nxt   = bus.iInv;
          w_cnt_nxt   = '0;
          w_state_nxt = SB_RUN;
        end
      end
      SB_RUN: begin
        w_work_nxt = w_work_sub;
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = SB_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      SB_DONE: begin
        if (bus.iReady) w_state_nxt = SB_IDLE;
      end
      default: w_state_nxt = SB_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= SB_IDLE;
      r_cnt   <= '0;
      r_inv   <= 1'b0;
      r_work  <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_inv   <= w_inv_nxt;
      r_work  <= w_work_nxt;
      r_ready <= (w_state_nxt == SB_IDLE);
      r_valid <= (w_state_nxt == SB_DONE);
    end
  end

  assign bus.oReady   = r_ready;
  assign bus.oValid   = r_valid;
  assign bus.oSubText = r_work;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Randomized self-checking bench for sub_bytes_iter against a table-based
// AES S-box model derived from GF(2^8) inversion by search.
module tb_sub_bytes_iter;

  localparam int unsigned BPC = 4;
  localparam int          K   = 16 / BPC;

  logic iClk = 1'b0;
  logic iRst;

  always #5 iClk = ~iClk;

  sub_bytes_iter_if bus();

  sub_bytes_iter #(.BYTES_PER_CYCLE(BPC)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic int ref_gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int bit_i = 14; bit_i >= 8; bit_i--)
      if (((p >> bit_i) & 1) != 0) p = p ^ ('h11b << (bit_i - 8));
    return p;
  endfunction

  task automatic build_tables();
    int inv_v, s;
    for (int x = 0; x < 256; x++) begin
      inv_v = 0;
      for (int y = 1; y < 256; y++) if (x != 0 && ref_gmul(x, y) == 1) inv_v = y;
      s = 0;
      for (int i = 0; i < 8; i++)
        s = s | ((((inv_v >> i) ^ (inv_v >> ((i + 4) % 8)) ^ (inv_v >> ((i + 5) % 8)) ^
                   (inv_v >> ((i + 6) % 8)) ^ (inv_v >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1) << i);
      sbox_t[x] = 8'(s);
    end
    for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] t, input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      b = 8'(t >> (8 * (15 - k)));
      r = {r[119:0], inv ? isbox_t[b] : sbox_t[b]};
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic send(input logic [127:0] t, input logic inv);
    bus.iValid = 1'b1;
    bus.iText  = t;
    bus.iInv   = inv;
    tick();
    bus.iValid = 1'b0;
    bus.iText  = rand128();
    bus.iInv   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.oValid !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_one(input string tag, input logic [127:0] t, input logic inv,
                         input int stall, input bit has_kat, input logic [127:0] kat);
    int lat;
    logic [127:0] exp;
    exp = ref_sub(t, inv);
    bus.iReady = (stall == 0);
    send(t, inv);
    check({tag, "_busy"}, 128'(bus.oReady), 128'(0));
    wait_valid(lat);
    check({tag, "_lat"}, 128'(lat), 128'(K));
    check({tag, "_data"}, bus.oSubText, exp);
    if (has_kat) check({tag, "_kat"}, bus.oSubText, kat);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_v"}, 128'(bus.oValid), 128'(1));
      check({tag, "_hold_d"}, bus.oSubText, exp);
    end
    bus.iReady = 1'b1;
    tick();
    check({tag, "_drop_v"}, 128'(bus.oValid), 128'(0));
    check({tag, "_rdy"}, 128'(bus.oReady), 128'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] t1, t2, exp2;
    int lat;
    bit seen;

    build_tables();
    iRst       = 1'b1;
    bus.iValid = 1'b1;
    bus.iText  = rand128();
    bus.iInv   = 1'b0;
    bus.iReady = 1'b0;

    // Reset with iValid pulsing: nothing accepted.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_valid", 128'(bus.oValid), 128'(0));
      check("rst_ready", 128'(bus.oReady), 128'(1));
      check("rst_text", bus.oSubText, 128'(0));
    end
    iRst       = 1'b0;
    bus.iValid = 1'b0;
    tick();
    check("post_rst_ready", 128'(bus.oReady), 128'(1));

    run_one("fips_fwd", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 0, 1'b1,
            128'hd42711aee0bf98f1b8b45de51e415230);
    run_one("fips_inv", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 0, 1'b1,
            128'h193de3bea0f4e22b9ac68d2ae9f84808);
    run_one("zeros", 128'h0, 1'b0, 0, 1'b1, {16{8'h63}});
    run_one("ones", {16{8'hff}}, 1'b0, 1, 1'b1, {16{8'h16}});

    // Backpressure with a new block held on the input.
    t1 = rand128();
    t2 = rand128();
    exp2 = ref_sub(t2, 1'b1);
    bus.iReady = 1'b0;
    send(t1, 1'b0);
    wait_valid(lat);
    check("bp_lat", 128'(lat), 128'(K));
    bus.iValid = 1'b1;
    bus.iText  = t2;
    bus.iInv   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_valid", 128'(bus.oValid), 128'(1));
      check("bp_data", bus.oSubText, ref_sub(t1, 1'b0));
      check("bp_ready", 128'(bus.oReady), 128'(0));
    end
    bus.iReady = 1'b1;
    tick();
    check("bp_idle", 128'(bus.oReady), 128'(1));
    tick();
    check("bp_accept", 128'(bus.oReady), 128'(0));
    bus.iValid = 1'b0;
    wait_valid(lat);
    check("bp_new_lat", 128'(lat), 128'(K));
    check("bp_new_data", bus.oSubText, exp2);
    tick();
    check("bp_new_drop", 128'(bus.oValid), 128'(0));

    // Reset while running aborts the block.
    bus.iReady = 1'b1;
    send(rand128(), 1'b0);
    tick();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    check("abort_ready", 128'(bus.oReady), 128'(1));
    check("abort_valid", 128'(bus.oValid), 128'(0));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.oValid === 1'b1) seen = 1'b1;
    end
    check("abort_no_pulse", 128'(seen), 128'(0));
    run_one("after_abort", 128'h00112233445566778899aabbccddeeff, 1'b0, 0, 1'b1,
            128'h638293c31bfc33f5c4eeacea4bc12816);

    for (int i = 0; i < 40; i++)
      run_one("rand", rand128(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
